// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundles the value-register side (load/value/masks) and the display pin side
// (anodes/segments plus status) of the seven-segment scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     blank;
    logic [NUM_DIGITS-1:0]     dash;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     an;
    logic [7:0]                seg;
    logic                      update_pending;
    logic                      frame_done;

    // load is a one-cycle strobe with no ready: the controller always accepts
    // it, and value/blank/dash/dp are sampled only in the cycle load is high.
    modport master (
        output load, value, blank, dash, dp,
        input  an, seg, update_pending, frame_done
    );

    modport slave (
        input  load, value, blank, dash, dp,
        output an, seg, update_pending, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Round-robin scan of a common-anode, active-low seven-segment display with
// per-slot anti-ghosting blanking and frame-synchronous commit of staged data.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] act_value, pend_value;
    logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
    logic [NUM_DIGITS-1:0]   act_dash, pend_dash;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic                    pend_flag;
    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [7:0]              seg_q;

    logic                    slot_end;
    logic                    frame_end;
    logic                    blank_phase;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end    = (div_cnt == CNT_LAST);
        frame_end   = slot_end && (digit_idx == IDX_LAST);
        blank_phase = (int'(div_cnt) < BLANK_CYCLES);
        an_next     = '1;
        seg_next    = 8'hFF;
        if (!blank_phase) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (int'(digit_idx) == i) begin
                    an_next[i] = 1'b0;
                    // blank wins over dash, dash wins over the hex glyph
                    if (act_blank[i])
                        seg_next = 8'hFF;
                    else if (act_dash[i])
                        seg_next = {~act_dp[i], 7'b0111111};
                    else
                        seg_next = {~act_dp[i], hex_to_seg(act_value[4*i +: 4])};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            digit_idx    <= '0;
            act_value    <= '0;
            act_blank    <= '1;
            act_dash     <= '0;
            act_dp       <= '0;
            pend_value   <= '0;
            pend_blank   <= '1;
            pend_dash    <= '0;
            pend_dp      <= '0;
            pend_flag    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
        end else begin
            frame_done_q <= frame_end;
            an_q         <= an_next;
            seg_q        <= seg_next;

            if (slot_end) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end

            // A load landing on the boundary bypasses staging and goes live directly.
            if (frame_end) begin
                if (bus.load) begin
                    act_value <= bus.value;
                    act_blank <= bus.blank;
                    act_dash  <= bus.dash;
                    act_dp    <= bus.dp;
                end else if (pend_flag) begin
                    act_value <= pend_value;
                    act_blank <= pend_blank;
                    act_dash  <= pend_dash;
                    act_dp    <= pend_dp;
                end
                pend_flag <= 1'b0;
            end else if (bus.load) begin
                pend_value <= bus.value;
                pend_blank <= bus.blank;
                pend_dash  <= bus.dash;
                pend_dp    <= bus.dp;
                pend_flag  <= 1'b1;
            end
        end
    end

    assign bus.an             = an_q;
    assign bus.seg            = seg_q;
    assign bus.update_pending = pend_flag;
    assign bus.frame_done     = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl: a frame-level model predicts the
// pins after every clock edge and a scoreboard queue carries the predictions.
module tb_seven_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * R;
    localparam int W     = N + 8 + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: k counts clock edges since reset release; displayed and staged data.
    int              k;
    logic [4*N-1:0]  m_act_val, m_pend_val;
    logic [N-1:0]    m_act_blank, m_pend_blank;
    logic [N-1:0]    m_act_dash, m_pend_dash;
    logic [N-1:0]    m_act_dp, m_pend_dp;
    logic            m_pend_flag;
    logic [W-1:0]    exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        k            = 0;
        m_act_val    = '0;  m_pend_val   = '0;
        m_act_blank  = '1;  m_pend_blank = '1;
        m_act_dash   = '0;  m_pend_dash  = '0;
        m_act_dp     = '0;  m_pend_dp    = '0;
        m_pend_flag  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] glyph(input int d);
        logic [3:0] h;
        h = m_act_val[4*d +: 4];
        if (m_act_blank[d]) return 8'hFF;
        if (m_act_dash[d])  return {~m_act_dp[d], 7'b0111111};
        return {~m_act_dp[d], hex_tab[h]};
    endfunction

    // Predict what the pins show right after the coming edge, then apply that edge's load.
    task automatic model_edge();
        int            pos, d;
        logic          boundary;
        logic [N-1:0]  e_an;
        logic [7:0]    e_seg;
        pos      = k % R;
        d        = (k / R) % N;
        boundary = (k % FRAME) == FRAME - 1;
        e_an     = '1;
        e_seg    = 8'hFF;
        if (pos >= B) begin
            e_an[d] = 1'b0;
            e_seg   = glyph(d);
        end
        if (boundary) begin
            if (bus.load) begin
                m_act_val = bus.value; m_act_blank = bus.blank;
                m_act_dash = bus.dash; m_act_dp = bus.dp;
            end else if (m_pend_flag) begin
                m_act_val = m_pend_val; m_act_blank = m_pend_blank;
                m_act_dash = m_pend_dash; m_act_dp = m_pend_dp;
            end
            m_pend_flag = 1'b0;
        end else if (bus.load) begin
            m_pend_val = bus.value; m_pend_blank = bus.blank;
            m_pend_dash = bus.dash; m_pend_dp = bus.dp;
            m_pend_flag = 1'b1;
        end
        exp_q.push_back({e_an, e_seg, m_pend_flag, boundary});
        k++;
    endtask

    task automatic step();
        logic [W-1:0] e;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("an", 32'(bus.an), 32'(e[W-1 -: N]));
        check("seg", 32'(bus.seg), 32'(e[9:2]));
        check("update_pending", 32'(bus.update_pending), 32'(e[1]));
        check("frame_done", 32'(bus.frame_done), 32'(e[0]));
        bus.load = 1'b0;
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] bl,
                           input logic [N-1:0] da, input logic [N-1:0] p);
        bus.value = v;
        bus.blank = bl;
        bus.dash  = da;
        bus.dp    = p;
        bus.load  = 1'b1;
        step();
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"}, 32'(bus.an), 32'hF);
        check({tag, "_seg"}, 32'(bus.seg), 32'hFF);
        check({tag, "_update_pending"}, 32'(bus.update_pending), 32'h0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = '0;
        bus.blank = '0;
        bus.dash  = '0;
        bus.dp    = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_dark("reset");
        reset = 1'b0;

        // No load yet: dark display, frame_done every FRAME cycles.
        repeat (2 * FRAME + 8) step();

        repeat (5) step();
        do_load(16'h12AF, 4'b0000, 4'b0000, 4'b0100);
        repeat (2 * FRAME) step();

        do_load(16'h12AF, 4'b0001, 4'b0010, 4'b0011);
        repeat (2 * FRAME) step();

        // Two staged loads inside one frame: only the last one may appear.
        repeat (3) step();
        do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
        repeat (4) step();
        do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
        repeat (2 * FRAME) step();

        // Load landing exactly on the frame boundary edge.
        while (k % FRAME != FRAME - 1) step();
        do_load(16'h8888, 4'b0000, 4'b0000, 4'b0000);
        repeat (2 * FRAME) step();

        repeat (600) begin
            if ($urandom_range(0, 11) == 0)
                do_load(16'($urandom),
                        ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                        ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                        4'($urandom));
            else
                step();
        end

        // Asynchronous reset in the lit part of a slot, with data still staged.
        while (k % R != 4) step();
        do_load(16'h3456, 4'b0000, 4'b0000, 4'b1111);
        step();
        reset = 1'b1;
        #1;
        check_dark("async_reset");
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        repeat (2 * FRAME) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
